// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the cache-refill FSM encoding.
// Imported by the refill master and its line buffer.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } refill_state_e;

    function automatic logic [2:0] axsize(input int width);
        return 3'($clog2(width / 8));
    endfunction

endpackage

// File: rtl/refill_line_buf.sv
// Cache-line assembly buffer with its beat counter.
// Beats past the end of the line are not stored; the count saturates.
module refill_line_buf
    import axi_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int BEATS  = 4,
    parameter int CNT_W  = $clog2(BEATS) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W*BEATS-1:0] line,
    output logic [CNT_W-1:0]        cnt
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BEATS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line <= '0;
            cnt  <= '0;
        end else if (clr) begin
            line <= '0;
            cnt  <= '0;
        end else if (wr && cnt < FULL) begin
            for (int i = 0; i < BEATS; i++) begin
                if (cnt == CNT_W'(i)) begin
                    line[i*DATA_W +: DATA_W] <= wdata;
                end
            end
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/axi_refill_master.sv
// AXI4 read-burst initiator that refills one cache line per request.
// Issues a single INCR burst and returns the assembled line with an error flag.
module axi_refill_master
    import axi_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int LINE_BEATS         = 4,
    parameter int AXI_ID             = 0
) (
    input  logic                                     M_AXI_ACLK,
    input  logic                                     M_AXI_ARESETN,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]            req_addr,
    output logic                                     rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH*LINE_BEATS-1:0] rsp_line,
    output logic                                     rsp_err,
    output logic                                     M_AXI_ARVALID,
    input  logic                                     M_AXI_ARREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]              M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_ARADDR,
    output logic [7:0]                               M_AXI_ARLEN,
    output logic [2:0]                               M_AXI_ARSIZE,
    output logic [1:0]                               M_AXI_ARBURST,
    input  logic                                     M_AXI_RVALID,
    output logic                                     M_AXI_RREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]              M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_RDATA,
    input  logic [1:0]                               M_AXI_RRESP,
    input  logic                                     M_AXI_RLAST
);

    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int CNT_W = $clog2(LINE_BEATS) + 1;
    localparam int OFF_W = $clog2(LINE_BEATS * DW / 8);

    localparam logic [AW-1:0] ADDR_MASK = ~((AW'(1) << OFF_W) - AW'(1));
    localparam logic [C_M_AXI_ID_WIDTH-1:0] ID = C_M_AXI_ID_WIDTH'(AXI_ID);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_BEATS - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(LINE_BEATS);

    refill_state_e    state, state_n;
    logic [AW-1:0]    addr;
    logic             err;
    logic [CNT_W-1:0] beat_cnt;
    logic             accept;
    logic             r_hs;
    logic             beat_err;
    logic             arvalid;
    logic             rready;
    logic             rsp_pulse;
    logic             idle_rdy;

    assign accept = req_valid && req_ready;
    assign r_hs   = M_AXI_RVALID && M_AXI_RREADY;

    // Any bad response, wrong ID, overrun or misplaced RLAST poisons the line
    always_comb begin
        beat_err = M_AXI_RRESP[1] || (M_AXI_RID != ID) || (beat_cnt >= FULL);
        if (M_AXI_RLAST) begin
            beat_err = beat_err || (beat_cnt != LAST);
        end else begin
            beat_err = beat_err || (beat_cnt == LAST);
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state <= ST_IDLE;
            addr  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr <= req_addr & ADDR_MASK;
                err  <= 1'b0;
            end else if (r_hs) begin
                err <= err || beat_err;
            end
        end
    end

    always_comb begin
        state_n   = state;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_pulse = 1'b0;
        idle_rdy  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                idle_rdy = 1'b1;
                if (req_valid) state_n = ST_ADDR;
            end
            ST_ADDR: begin
                arvalid = 1'b1;
                if (M_AXI_ARREADY) state_n = ST_DATA;
            end
            ST_DATA: begin
                rready = 1'b1;
                if (M_AXI_RVALID && M_AXI_RLAST) state_n = ST_RESP;
            end
            ST_RESP: begin
                rsp_pulse = 1'b1;
                state_n   = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    refill_line_buf #(
        .DATA_W (DW),
        .BEATS  (LINE_BEATS),
        .CNT_W  (CNT_W)
    ) u_line_buf (
        .clk    (M_AXI_ACLK),
        .rst_n  (M_AXI_ARESETN),
        .clr    (accept),
        .wr     (r_hs),
        .wdata  (M_AXI_RDATA),
        .line   (rsp_line),
        .cnt    (beat_cnt)
    );

    assign req_ready     = idle_rdy && M_AXI_ARESETN;
    assign rsp_valid     = rsp_pulse;
    assign rsp_err       = err;
    assign M_AXI_ARVALID = arvalid;
    assign M_AXI_RREADY  = rready;
    assign M_AXI_ARID    = ID;
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARLEN   = 8'(LINE_BEATS - 1);
    assign M_AXI_ARSIZE  = axsize(DW);
    assign M_AXI_ARBURST = BURST_INCR;

endmodule

// File: doc/axi_refill_master.md
Name: axi_refill_master

Overview:
AXI4 read-burst initiator for cache-line refill. It sits between the instruction/data cache miss logic and the AXI4 memory slave.
- Accepts one line-address request on a simple valid/ready port.
- Issues one INCR burst of LINE_BEATS beats on AR.
- Collects the R beats into a line buffer.
- Returns the whole line plus an error flag as a one-cycle response pulse.

Parameters:
C_M_AXI_ID_WIDTH, 4, width of ARID/RID
C_M_AXI_DATA_WIDTH, 64, R data width (32 or 64)
C_M_AXI_ADDR_WIDTH, 32, address width
LINE_BEATS, 4, beats per cache line (power of 2, 2..16)
AXI_ID, 0, constant ID driven on ARID

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  reset; one clock, synchronous, active-low
req_valid  in  1  refill request
req_ready  out  1  high only in IDLE and not in reset
req_addr  in  ADDR_W  miss address (any byte offset)
rsp_valid  out  1  one-cycle pulse: line complete
rsp_line  out  DATA_W*LINE_BEATS  refilled line; beat 0 in the LSBs
rsp_err  out  1  burst had an error (qualified by rsp_valid)
M_AXI_ARVALID  out  1  AR valid
M_AXI_ARREADY  in  1  AR ready
M_AXI_ARID  out  ID_W  = AXI_ID
M_AXI_ARADDR  out  ADDR_W  line-aligned address
M_AXI_ARLEN  out  8  = LINE_BEATS-1
M_AXI_ARSIZE  out  3  = log2(DATA_W/8)
M_AXI_ARBURST  out  2  = 2'b01 (INCR)
M_AXI_RVALID  in  1  R valid
M_AXI_RREADY  out  1  R ready
M_AXI_RID  in  ID_W  R ID
M_AXI_RDATA  in  DATA_W  R data
M_AXI_RRESP  in  2  R response
M_AXI_RLAST  in  1  R last

Behaviour:
- FSM has four states: IDLE, ADDR, DATA, RESP.
- Reset (ARESETN=0 at a clock edge):
  - state=IDLE, beat_cnt=0.
  - ARVALID=0, RREADY=0, rsp_valid=0, rsp_err=0, rsp_line=0, ARADDR=0.
  - req_ready=0 while ARESETN is low.
  - Reset mid-burst abandons the transaction silently: no rsp_valid.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch addr with the low log2(LINE_BEATS*DATA_W/8) bits cleared; clear the line buffer; clear err; beat_cnt=0; go to ADDR.
- ADDR:
  - ARVALID=1 from the cycle after acceptance.
  - ARADDR/ARLEN/ARSIZE/ARBURST/ARID stay stable until ARREADY.
  - On ARVALID&&ARREADY: go to DATA; ARVALID=0 next cycle.
  - ARVALID is never dropped before its handshake.
- DATA:
  - RREADY=1.
  - On each RVALID&&RREADY: if beat_cnt<LINE_BEATS, store RDATA into slot beat_cnt, then beat_cnt+1. Beats beyond LINE_BEATS are dropped and set err.
  - err |= RRESP[1] (SLVERR/DECERR).
  - err |= (RID != AXI_ID).
  - On the RLAST beat:
    - err |= (beat_cnt != LINE_BEATS-1), covering early RLAST; unfilled slots stay 0.
    - go to RESP.
  - A missing RLAST on beat LINE_BEATS-1 sets err, and the block keeps accepting until RLAST.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_err=err; return to IDLE.
  - There is no response backpressure.
  - rsp_line holds its value until the next request is accepted.
- Latency:
  - ARVALID appears 1 cycle after acceptance.
  - rsp_valid appears 1 cycle after the RLAST handshake.
  - A new request can be accepted 1 cycle after rsp_valid.
- Boundary rules:
  - req_valid outside IDLE is ignored and not stored.
  - RVALID seen in IDLE/ADDR/RESP is not consumed (RREADY=0).
  - All AXI outputs come from registers or state decode, with no combinational input->output path.

Decomposition:
- Shared package axi_pkg:
  - BURST_FIXED/INCR/WRAP constants.
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - axsize-from-width constant function.
  - refill FSM state encoding.
- The line buffer plus beat counter fits naturally in a sub-module refill_line_buf (write-enable, index, clear, data out). FSM and AR logic stay in the top.

Test Plan:
- Basic refill: req_addr=0x8000_0014, DATA_W=64, LINE_BEATS=4 -> ARADDR=0x8000_0000, ARLEN=3, ARSIZE=3, ARBURST=1; R beats 0x11..,0x22..,0x33..,0x44.. with RLAST on beat 3 -> one rsp_valid pulse, rsp_line={0x44..,0x33..,0x22..,0x11..}, rsp_err=0.
- AR backpressure: ARREADY held low for 5 cycles -> ARVALID high and ARADDR stable for all 6 cycles, one handshake, req_ready=0 throughout.
- R gaps: RVALID toggles every other cycle; req_valid pulsed during DATA -> line assembled in order; the extra request is ignored with no second AR.
- Error: RRESP=2'b10 on beat 2 -> rsp_err=1 and all 4 beats stored. Early RLAST on beat 1 -> rsp_err=1, slots 2–3 =0.
- Reset mid-burst: deassert ARESETN after 2 beats -> ARVALID=RREADY=rsp_valid=0, no response. The next request completes normally with rsp_err=0.
